// File: rtl/control_peatonal.sv
`default_nettype none
// ============================================================================
// Module      : control_peatonal
// Description : Pedestrian-head driver for crossings A/B downstream of the
//               traffic-light controller, with a sticky safety fault monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module control_peatonal #(
  parameter int WALK_CYC    = 8,
  parameter int FLASH_DIV   = 2,
  parameter int FLASH_STEPS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENB,
  input  logic [1:0] Semaforo_A,
  input  logic [1:0] Semaforo_B,
  input  logic       A_Peatonal,
  input  logic       B_Peatonal,
  output logic       Caminar_A,
  output logic       Alto_A,
  output logic [3:0] Cuenta_A,
  output logic       Caminar_B,
  output logic       Alto_B,
  output logic [3:0] Cuenta_B,
  output logic       Falla
);

  localparam int c_tmax = (WALK_CYC > FLASH_DIV) ? WALK_CYC : FLASH_DIV;
  localparam int c_tw   = (c_tmax > 1) ? $clog2(c_tmax) : 1;
  localparam logic [c_tw-1:0] c_walk_last = c_tw'(WALK_CYC - 1);
  localparam logic [c_tw-1:0] c_div_last  = c_tw'(FLASH_DIV - 1);
  localparam logic [3:0]      c_steps     = 4'(FLASH_STEPS);

  typedef enum logic [1:0] {
    NO_CAMINAR = 2'd0,
    CAMINAR    = 2'd1,
    PARPADEO   = 2'd2
  } state_t;

  logic       w_fault;
  logic       r_falla;
  logic [1:0] w_pea;

  assign w_pea = {B_Peatonal, A_Peatonal};

  // Unsafe controller combinations: both green, invalid code, or a permit
  // granted while the matching vehicle light is not red.
  assign w_fault = ((Semaforo_A == 2'b10) && (Semaforo_B == 2'b10)) ||
                   (Semaforo_A == 2'b11) || (Semaforo_B == 2'b11) ||
                   (A_Peatonal && (Semaforo_A != 2'b00)) ||
                   (B_Peatonal && (Semaforo_B != 2'b00));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_falla <= 1'b0;
    end else if (ENB && w_fault) begin
      r_falla <= 1'b1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_chan
    state_t          r_state;
    logic [c_tw-1:0] r_timer;
    logic            r_prev;
    logic            r_caminar;
    logic            r_alto;
    logic [3:0]      r_cuenta;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_state   <= NO_CAMINAR;
        r_timer   <= '0;
        r_prev    <= 1'b0;
        r_caminar <= 1'b0;
        r_alto    <= 1'b1;
        r_cuenta  <= 4'd0;
      end else if (ENB) begin
        r_prev <= w_pea[i];
        // A fault (new or latched) beats any request edge in the same cycle.
        if (w_fault || r_falla) begin
          r_state   <= NO_CAMINAR;
          r_timer   <= '0;
          r_caminar <= 1'b0;
          r_alto    <= 1'b1;
          r_cuenta  <= 4'd0;
        end else begin
          case (r_state)
            NO_CAMINAR: begin
              if (w_pea[i] && !r_prev) begin
                r_state   <= CAMINAR;
                r_timer   <= '0;
                r_caminar <= 1'b1;
                r_alto    <= 1'b0;
                r_cuenta  <= 4'd0;
              end
            end
            CAMINAR: begin
              if (!w_pea[i]) begin
                r_state   <= NO_CAMINAR;
                r_timer   <= '0;
                r_caminar <= 1'b0;
                r_alto    <= 1'b1;
                r_cuenta  <= 4'd0;
              end else if (r_timer == c_walk_last) begin
                r_state   <= PARPADEO;
                r_timer   <= '0;
                r_caminar <= 1'b0;
                r_alto    <= c_steps[0];
                r_cuenta  <= c_steps;
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
            PARPADEO: begin
              if (!w_pea[i]) begin
                r_state  <= NO_CAMINAR;
                r_timer  <= '0;
                r_alto   <= 1'b1;
                r_cuenta <= 4'd0;
              end else if (r_timer == c_div_last) begin
                r_timer <= '0;
                if (r_cuenta == 4'd1) begin
                  r_state  <= NO_CAMINAR;
                  r_alto   <= 1'b1;
                  r_cuenta <= 4'd0;
                end else begin
                  // Don't-walk is lit on odd countdown values.
                  r_alto   <= ~r_cuenta[0];
                  r_cuenta <= r_cuenta - 4'd1;
                end
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
            default: begin
              r_state   <= NO_CAMINAR;
              r_timer   <= '0;
              r_caminar <= 1'b0;
              r_alto    <= 1'b1;
              r_cuenta  <= 4'd0;
            end
          endcase
        end
      end
    end
  end

  assign Caminar_A = g_chan[0].r_caminar;
  assign Alto_A    = g_chan[0].r_alto;
  assign Cuenta_A  = g_chan[0].r_cuenta;
  assign Caminar_B = g_chan[1].r_caminar;
  assign Alto_B    = g_chan[1].r_alto;
  assign Cuenta_B  = g_chan[1].r_cuenta;
  assign Falla     = r_falla;

endmodule
`default_nettype wire
